// File: rtl/k503_sprite_scheduler.sv
// Per-scanline sprite scan sequencer: walks object RAM, applies the 503 Y hit test
// and queues up to MAX_PER_LINE hits. Define K503_SCHED_REVERSE_EN to scan high index first.
module k503_sprite_scheduler #(
  parameter int NUM_SPRITES  = 24,
  parameter int MAX_PER_LINE = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CEN,
  input  logic       LINE_START,
  input  logic [7:0] VCNT,
  output logic [6:0] OBJ_ADDR,
  input  logic [7:0] OBJ_DATA,
  output logic       SPR_VALID,
  input  logic       SPR_READY,
  output logic [4:0] SPR_INDEX,
  output logic [3:0] SPR_ROW,
  output logic       SPR_HFLIP,
  output logic       SPR_VFLIP,
  output logic       BUSY,
  output logic       LINE_OVERFLOW
);

  localparam int PW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
  localparam int CW = PW + 1;
  localparam logic [4:0] IDX_LAST = 5'(NUM_SPRITES - 1);
`ifdef K503_SCHED_REVERSE_EN
  localparam logic [4:0] IDX_FIRST = IDX_LAST;
  localparam logic [4:0] IDX_END   = 5'd0;
`else
  localparam logic [4:0] IDX_FIRST = 5'd0;
  localparam logic [4:0] IDX_END   = IDX_LAST;
`endif

  typedef enum logic [2:0] {IDLE, RD_Y, EV_Y, RD_ATTR, EV_ATTR, PUSH, NEXT, DONE} state_t;

  typedef struct packed {
    logic [4:0] idx;
    logic [3:0] row;
    logic       hflip;
    logic       vflip;
  } spr_ent_t;

  state_t          state_q, state_d;
  logic [4:0]      idx_q, idx_d, idx_nxt;
  logic [7:0]      vcnt_q, vcnt_d;
  logic [3:0]      row_q, row_d;
  logic            hflip_q, hflip_d, vflip_q, vflip_d;
  logic [CW-1:0]   hit_cnt_q, hit_cnt_d;
  logic            ovf_q, ovf_d;
  logic [6:0]      addr_q, addr_d;
  spr_ent_t        mem_q [MAX_PER_LINE];
  spr_ent_t        mem_d [MAX_PER_LINE];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      sum;
  logic            push, pop, flush;

  assign sum = OBJ_DATA + vcnt_q;

`ifdef K503_SCHED_REVERSE_EN
  assign idx_nxt = idx_q - 5'd1;
`else
  assign idx_nxt = idx_q + 5'd1;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vcnt_d    = vcnt_q;
    row_d     = row_q;
    hflip_d   = hflip_q;
    vflip_d   = vflip_q;
    hit_cnt_d = hit_cnt_q;
    ovf_d     = ovf_q;
    addr_d    = addr_q;
    push      = 1'b0;
    flush     = 1'b0;
    if (CEN) begin
      if (LINE_START) begin
        // A new line aborts any scan in flight; nothing partial reaches the FIFO.
        vcnt_d    = VCNT;
        idx_d     = IDX_FIRST;
        hit_cnt_d = '0;
        ovf_d     = 1'b0;
        addr_d    = {IDX_FIRST, 2'd0};
        flush     = 1'b1;
        state_d   = RD_Y;
      end else begin
        case (state_q)
          RD_Y:    state_d = EV_Y;
          EV_Y: begin
            row_d = sum[3:0];
            if (sum[7:4] == 4'hF) begin
              addr_d  = {idx_q, 2'd1};
              state_d = RD_ATTR;
            end else begin
              state_d = NEXT;
            end
          end
          RD_ATTR: state_d = EV_ATTR;
          EV_ATTR: begin
            vflip_d = OBJ_DATA[7];
            hflip_d = OBJ_DATA[6];
            state_d = PUSH;
          end
          PUSH: begin
            if (hit_cnt_q == CW'(MAX_PER_LINE)) begin
              ovf_d   = 1'b1;
              state_d = DONE;
            end else begin
              push      = 1'b1;
              hit_cnt_d = hit_cnt_q + CW'(1);
              state_d   = NEXT;
            end
          end
          NEXT: begin
            if (idx_q == IDX_END) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_nxt;
              addr_d  = {idx_nxt, 2'd0};
              state_d = RD_Y;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    pop      = CEN && SPR_READY && (cnt_q != '0) && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{idx: idx_q, row: row_q ^ {4{vflip_q}}, hflip: hflip_q, vflip: vflip_q};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      vcnt_q    <= '0;
      row_q     <= '0;
      hflip_q   <= 1'b0;
      vflip_q   <= 1'b0;
      hit_cnt_q <= '0;
      ovf_q     <= 1'b0;
      addr_q    <= '0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vcnt_q    <= vcnt_d;
      row_q     <= row_d;
      hflip_q   <= hflip_d;
      vflip_q   <= vflip_d;
      hit_cnt_q <= hit_cnt_d;
      ovf_q     <= ovf_d;
      addr_q    <= addr_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign OBJ_ADDR      = addr_q;
  assign SPR_VALID     = (cnt_q != '0);
  assign SPR_INDEX     = mem_q[rd_ptr_q].idx;
  assign SPR_ROW       = mem_q[rd_ptr_q].row;
  assign SPR_HFLIP     = mem_q[rd_ptr_q].hflip;
  assign SPR_VFLIP     = mem_q[rd_ptr_q].vflip;
  assign BUSY          = (state_q != IDLE) && (state_q != DONE);
  assign LINE_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_k503_sprite_scheduler.sv
// Directed bench for k503_sprite_scheduler: hit/miss, flips, wrap, overflow, abort,
// mid-scan reset and CEN/backpressure ordering against hand-built expectations.
module tb_k503_sprite_scheduler;

`ifdef K503_SCHED_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET, CEN, LINE_START, SPR_READY;
  logic [7:0] VCNT, OBJ_DATA;
  logic [6:0] OBJ_ADDR;
  logic       SPR_VALID, SPR_HFLIP, SPR_VFLIP, BUSY, LINE_OVERFLOW;
  logic [4:0] SPR_INDEX;
  logic [3:0] SPR_ROW;

  k503_sprite_scheduler #(.NUM_SPRITES(24), .MAX_PER_LINE(8)) dut (
    .CLK(CLK), .RESET(RESET), .CEN(CEN), .LINE_START(LINE_START), .VCNT(VCNT),
    .OBJ_ADDR(OBJ_ADDR), .OBJ_DATA(OBJ_DATA), .SPR_VALID(SPR_VALID), .SPR_READY(SPR_READY),
    .SPR_INDEX(SPR_INDEX), .SPR_ROW(SPR_ROW), .SPR_HFLIP(SPR_HFLIP), .SPR_VFLIP(SPR_VFLIP),
    .BUSY(BUSY), .LINE_OVERFLOW(LINE_OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read object RAM model
  logic [7:0] mem [128];
  always @(posedge CLK) if (CEN) OBJ_DATA <= mem[OBJ_ADDR];

  int n_chk = 0;
  int n_pass = 0;
  logic [10:0] got_q[$];
  logic [10:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [10:0] ent(input int i, input int r, input bit h, input bit v);
    return {i[4:0], r[3:0], h, v};
  endfunction

  task automatic add_exp(input logic [10:0] e);
    if (REV) exp_q.push_front(e);
    else exp_q.push_back(e);
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
  endtask

  task automatic set_spr(input int i, input logic [7:0] y, input logic [7:0] attr);
    mem[i*4]   = y;
    mem[i*4+1] = attr;
  endtask

  task automatic pulse(input logic [7:0] v);
    LINE_START = 1'b1;
    VCNT = v;
    tick();
    LINE_START = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (BUSY && cyc < 1000) begin
      tick();
      cyc++;
    end
    if (cyc >= 1000) chk("busy_timeout", 32'(BUSY), 32'd0);
  endtask

  task automatic drain();
    got_q.delete();
    SPR_READY = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (!SPR_VALID) break;
      got_q.push_back({SPR_INDEX, SPR_ROW, SPR_HFLIP, SPR_VFLIP});
      tick();
    end
    SPR_READY = 1'b0;
  endtask

  task automatic cmp_list(input string tag);
    chk({tag, "_n"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
  endtask

  task automatic cen_run(input bit toggle);
    int it;
    got_q.delete();
    CEN = 1'b1;
    SPR_READY = 1'b0;
    pulse(8'h20);
    it = 0;
    while ((BUSY || SPR_VALID) && it < 3000) begin
      if (toggle) begin
        CEN = it[0];
        SPR_READY = 1'($urandom_range(0, 1));
      end else begin
        CEN = 1'b1;
        SPR_READY = 1'b1;
      end
      if (SPR_VALID && SPR_READY && CEN) got_q.push_back({SPR_INDEX, SPR_ROW, SPR_HFLIP, SPR_VFLIP});
      tick();
      it++;
    end
    if (it >= 3000) chk("cen_timeout", 32'(BUSY), 32'd0);
    CEN = 1'b1;
    SPR_READY = 1'b0;
  endtask

  initial begin
    int cyc;
    RESET = 1'b1; CEN = 1'b1; LINE_START = 1'b0; VCNT = 8'h00; SPR_READY = 1'b0;
    clr_mem();
    tick(); tick();
    chk("rst_addr", 32'(OBJ_ADDR), 0);
    chk("rst_valid", 32'(SPR_VALID), 0);
    chk("rst_head", 32'({SPR_INDEX, SPR_ROW, SPR_HFLIP, SPR_VFLIP}), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_ovf", 32'(LINE_OVERFLOW), 0);
    RESET = 1'b0;
    tick();
    chk("idle_busy", 32'(BUSY), 0);

    // Single hit at sprite 0: 23 misses + 1 hit
    set_spr(0, 8'hE0, 8'h00);
    pulse(8'h15);
    chk("hit_busy", 32'(BUSY), 1);
    wait_idle(cyc);
    chk("hit_cyc", 32'(cyc), 75);
    drain();
    exp_q.delete(); add_exp(ent(0, 5, 0, 0));
    cmp_list("hit");

    // All miss
    set_spr(0, 8'h10, 8'h00);
    pulse(8'h15);
    wait_idle(cyc);
    chk("miss_cyc", 32'(cyc), 72);
    drain();
    exp_q.delete();
    cmp_list("miss");

    // Flips
    set_spr(3, 8'hE0, 8'hC0);
    pulse(8'h15);
    wait_idle(cyc);
    chk("flip_cyc", 32'(cyc), 75);
    drain();
    exp_q.delete(); add_exp(ent(3, 4'hA, 1, 1));
    cmp_list("flip");

    // Wrap-around: F8+02=FA hit, F8+08=00 miss
    set_spr(3, 8'hF8, 8'h00);
    pulse(8'h02);
    wait_idle(cyc);
    drain();
    exp_q.delete(); add_exp(ent(3, 4'hA, 0, 0));
    cmp_list("wrap_hit");
    pulse(8'h08);
    wait_idle(cyc);
    chk("wrap_miss_cyc", 32'(cyc), 72);
    drain();
    exp_q.delete();
    cmp_list("wrap_miss");

    // Overflow: 8 hits queued, 9th hit ends the line
    for (int i = 0; i < 24; i++) set_spr(i, 8'hF0, 8'h00);
    pulse(8'h00);
    wait_idle(cyc);
    chk("ovf_cyc", 32'(cyc), 53);
    chk("ovf_flag", 32'(LINE_OVERFLOW), 1);
    drain();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(REV ? 23 - i : i, 0, 0, 0));
    cmp_list("ovf");
    chk("ovf_hold", 32'(LINE_OVERFLOW), 1);
    clr_mem();
    pulse(8'h00);
    chk("ovf_clr", 32'(LINE_OVERFLOW), 0);
    wait_idle(cyc);
    chk("ovf_clr_cyc", 32'(cyc), 72);

    // Abort mid-scan: restart with new VCNT, only the new line's hit appears
    for (int i = 0; i < 4; i++) set_spr(i, 8'hF0, 8'h00);
    set_spr(10, 8'hF0, 8'h00);
    set_spr(5, 8'hE0, 8'h00);
    pulse(8'h00);
    repeat (45) tick();
    chk("abort_pre_valid", 32'(SPR_VALID), 1);
    pulse(8'h10);
    chk("abort_flush", 32'(SPR_VALID), 0);
    chk("abort_busy", 32'(BUSY), 1);
    wait_idle(cyc);
    chk("abort_cyc", 32'(cyc), 75);
    drain();
    exp_q.delete(); add_exp(ent(5, 0, 0, 0));
    cmp_list("abort");

    // Reset mid-scan with CEN low
    for (int i = 0; i < 24; i++) set_spr(i, 8'hF0, 8'h00);
    pulse(8'h00);
    repeat (20) tick();
    chk("mrst_pre_busy", 32'(BUSY), 1);
    chk("mrst_pre_valid", 32'(SPR_VALID), 1);
    CEN = 1'b0; RESET = 1'b1;
    tick();
    chk("mrst_busy", 32'(BUSY), 0);
    chk("mrst_valid", 32'(SPR_VALID), 0);
    chk("mrst_addr", 32'(OBJ_ADDR), 0);
    chk("mrst_head", 32'({SPR_INDEX, SPR_ROW, SPR_HFLIP, SPR_VFLIP}), 0);
    RESET = 1'b0; CEN = 1'b1;
    tick();

    // CEN toggling and random backpressure, VCNT=0x20
    clr_mem();
    set_spr(1,  8'hD3, 8'h40);
    set_spr(4,  8'hDF, 8'h80);
    set_spr(5,  8'hD0, 8'h00);
    set_spr(9,  8'hD7, 8'hC0);
    set_spr(12, 8'hE0, 8'hC0);
    set_spr(13, 8'hCF, 8'h00);
    set_spr(20, 8'hDA, 8'h40);
    set_spr(23, 8'hD5, 8'h80);
    exp_q.delete();
    add_exp(ent(1, 3, 1, 0));
    add_exp(ent(4, 0, 0, 1));
    add_exp(ent(5, 0, 0, 0));
    add_exp(ent(9, 8, 1, 1));
    add_exp(ent(20, 4'hA, 1, 0));
    add_exp(ent(23, 4'hA, 0, 1));
    cen_run(1'b0);
    cmp_list("gold");
    cen_run(1'b1);
    cmp_list("cen");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
